// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Request, ALU, result and flag-write signals of alu_issue_ctrl.
// Revision : 1.0
// ============================================================================
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_s;
    logic        req_wide;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] req_a_hi;
    logic [31:0] req_b_hi;
    logic        req_shc;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cf;
    logic        alu_vf;
    logic        alu_shc;
    logic [31:0] alu_f;
    logic [3:0]  alu_nzcv;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_f;
    logic [31:0] res_f_hi;
    logic        res_we;

    logic        flag_wr_en;
    logic [3:0]  flag_wr_data;
    logic [3:0]  nzcv;

    // Environment side: request source, combinational ALU, result sink, MSR writer
    modport master (
        output req_valid, req_op, req_s, req_wide, req_a, req_b, req_a_hi, req_b_hi, req_shc,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_shc,
        output alu_f, alu_nzcv,
        input  res_valid, res_f, res_f_hi, res_we,
        output res_ready,
        output flag_wr_en, flag_wr_data,
        input  nzcv
    );

    modport slave (
        input  req_valid, req_op, req_s, req_wide, req_a, req_b, req_a_hi, req_b_hi, req_shc,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_shc,
        input  alu_f, alu_nzcv,
        output res_valid, res_f, res_f_hi, res_we,
        input  res_ready,
        input  flag_wr_en, flag_wr_data,
        output nzcv
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Sequences requests through the combinational ALU (one or two
//            passes), registers the result and owns the NZCV flag register.
// Revision : 1.0
// ============================================================================
module alu_issue_ctrl #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_issue_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        c_IDLE    = 2'd0,
        c_EXEC_LO = 2'd1,
        c_EXEC_HI = 2'd2,
        c_DONE    = 2'd3
    } state_t;

    state_t         r_state_q,     w_state_d;
    logic           r_req_ready_q, w_req_ready_d;
    logic           r_res_valid_q, w_res_valid_d;
    logic [31:0]    r_res_f_q,     w_res_f_d;
    logic [31:0]    r_res_f_hi_q,  w_res_f_hi_d;
    logic           r_res_we_q,    w_res_we_d;
    logic [3:0]     r_nzcv_q,      w_nzcv_d;
    logic [31:0]    r_alu_a_q,     w_alu_a_d;
    logic [31:0]    r_alu_b_q,     w_alu_b_d;
    logic [3:0]     r_alu_op_q,    w_alu_op_d;
    logic           r_alu_cf_q,    w_alu_cf_d;
    logic           r_alu_vf_q,    w_alu_vf_d;
    logic           r_alu_shc_q,   w_alu_shc_d;
    logic [3:0]     r_op_q,        w_op_d;
    logic           r_s_q,         w_s_d;
    logic           r_wide_q,      w_wide_d;
    logic [W-1:0]   r_a_hi_q,      w_a_hi_d;
    logic [W-1:0]   r_b_hi_q,      w_b_hi_d;
    logic [31:0]    r_f_lo_q,      w_f_lo_d;
    logic           r_z_lo_q,      w_z_lo_d;

    logic           w_is_cmp;
    logic           w_flag_upd;
    logic [3:0]     w_flag_new;

    // High pass turns carry-consuming arithmetic into its carry-chained form
    function automatic logic [3:0] f_remap_hi(input logic [3:0] op);
        case (op)
            4'b0100: f_remap_hi = 4'b0101;
            4'b0010: f_remap_hi = 4'b0110;
            4'b0011: f_remap_hi = 4'b0111;
            4'b1010: f_remap_hi = 4'b0110;
            4'b1011: f_remap_hi = 4'b0101;
            default: f_remap_hi = op;
        endcase
    endfunction

    assign w_is_cmp = (r_op_q[3:2] == 2'b10);

    always_comb begin
        w_state_d     = r_state_q;
        w_req_ready_d = r_req_ready_q;
        w_res_valid_d = r_res_valid_q;
        w_res_f_d     = r_res_f_q;
        w_res_f_hi_d  = r_res_f_hi_q;
        w_res_we_d    = r_res_we_q;
        w_alu_a_d     = r_alu_a_q;
        w_alu_b_d     = r_alu_b_q;
        w_alu_op_d    = r_alu_op_q;
        w_alu_cf_d    = r_alu_cf_q;
        w_alu_vf_d    = r_alu_vf_q;
        w_alu_shc_d   = r_alu_shc_q;
        w_op_d        = r_op_q;
        w_s_d         = r_s_q;
        w_wide_d      = r_wide_q;
        w_a_hi_d      = r_a_hi_q;
        w_b_hi_d      = r_b_hi_q;
        w_f_lo_d      = r_f_lo_q;
        w_z_lo_d      = r_z_lo_q;
        w_flag_upd    = 1'b0;
        w_flag_new    = bus.alu_nzcv;

        case (r_state_q)
            c_IDLE: begin
                if (bus.req_valid) begin
                    w_op_d        = bus.req_op;
                    w_s_d         = bus.req_s;
                    w_wide_d      = bus.req_wide;
                    w_a_hi_d      = bus.req_a_hi;
                    w_b_hi_d      = bus.req_b_hi;
                    w_alu_a_d     = bus.req_a;
                    w_alu_b_d     = bus.req_b;
                    w_alu_op_d    = bus.req_op;
                    w_alu_shc_d   = bus.req_shc;
                    // C/V are frozen here so later MSR writes cannot disturb the op
                    w_alu_cf_d    = r_nzcv_q[1];
                    w_alu_vf_d    = r_nzcv_q[0];
                    w_req_ready_d = 1'b0;
                    w_state_d     = c_EXEC_LO;
                end
            end
            c_EXEC_LO: begin
                w_f_lo_d = bus.alu_f;
                w_z_lo_d = bus.alu_nzcv[2];
                if (r_wide_q) begin
                    w_alu_a_d   = r_a_hi_q;
                    w_alu_b_d   = r_b_hi_q;
                    w_alu_op_d  = f_remap_hi(r_op_q);
                    w_alu_cf_d  = bus.alu_nzcv[1];
                    w_alu_shc_d = bus.alu_nzcv[1];
                    w_state_d   = c_EXEC_HI;
                end else begin
                    w_res_f_d     = bus.alu_f;
                    w_res_f_hi_d  = 32'd0;
                    w_res_we_d    = ~w_is_cmp;
                    w_res_valid_d = 1'b1;
                    w_flag_upd    = r_s_q | w_is_cmp;
                    w_state_d     = c_DONE;
                end
            end
            c_EXEC_HI: begin
                w_res_f_d     = r_f_lo_q;
                w_res_f_hi_d  = bus.alu_f;
                w_res_we_d    = ~w_is_cmp;
                w_res_valid_d = 1'b1;
                w_flag_upd    = r_s_q | w_is_cmp;
                w_flag_new    = {bus.alu_nzcv[3], bus.alu_nzcv[2] & r_z_lo_q, bus.alu_nzcv[1:0]};
                w_state_d     = c_DONE;
            end
            c_DONE: begin
                if (bus.res_ready) begin
                    w_res_valid_d = 1'b0;
                    w_req_ready_d = 1'b1;
                    w_state_d     = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase

        // Internal update has priority over a coincident MSR write
        if (w_flag_upd) begin
            w_nzcv_d = w_flag_new;
        end else if (bus.flag_wr_en) begin
            w_nzcv_d = bus.flag_wr_data;
        end else begin
            w_nzcv_d = r_nzcv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_IDLE;
            r_req_ready_q <= 1'b1;
            r_res_valid_q <= 1'b0;
            r_res_f_q     <= 32'd0;
            r_res_f_hi_q  <= 32'd0;
            r_res_we_q    <= 1'b0;
            r_nzcv_q      <= 4'd0;
            r_alu_a_q     <= 32'd0;
            r_alu_b_q     <= 32'd0;
            r_alu_op_q    <= 4'd0;
            r_alu_cf_q    <= 1'b0;
            r_alu_vf_q    <= 1'b0;
            r_alu_shc_q   <= 1'b0;
            r_op_q        <= 4'd0;
            r_s_q         <= 1'b0;
            r_wide_q      <= 1'b0;
            r_a_hi_q      <= '0;
            r_b_hi_q      <= '0;
            r_f_lo_q      <= 32'd0;
            r_z_lo_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_req_ready_q <= w_req_ready_d;
            r_res_valid_q <= w_res_valid_d;
            r_res_f_q     <= w_res_f_d;
            r_res_f_hi_q  <= w_res_f_hi_d;
            r_res_we_q    <= w_res_we_d;
            r_nzcv_q      <= w_nzcv_d;
            r_alu_a_q     <= w_alu_a_d;
            r_alu_b_q     <= w_alu_b_d;
            r_alu_op_q    <= w_alu_op_d;
            r_alu_cf_q    <= w_alu_cf_d;
            r_alu_vf_q    <= w_alu_vf_d;
            r_alu_shc_q   <= w_alu_shc_d;
            r_op_q        <= w_op_d;
            r_s_q         <= w_s_d;
            r_wide_q      <= w_wide_d;
            r_a_hi_q      <= w_a_hi_d;
            r_b_hi_q      <= w_b_hi_d;
            r_f_lo_q      <= w_f_lo_d;
            r_z_lo_q      <= w_z_lo_d;
        end
    end

    assign bus.req_ready = r_req_ready_q;
    assign bus.res_valid = r_res_valid_q;
    assign bus.res_f     = r_res_f_q;
    assign bus.res_f_hi  = r_res_f_hi_q;
    assign bus.res_we    = r_res_we_q;
    assign bus.nzcv      = r_nzcv_q;
    assign bus.alu_a     = r_alu_a_q;
    assign bus.alu_b     = r_alu_b_q;
    assign bus.alu_op    = r_alu_op_q;
    assign bus.alu_cf    = r_alu_cf_q;
    assign bus.alu_vf    = r_alu_vf_q;
    assign bus.alu_shc   = r_alu_shc_q;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer in front of the combinational ALU (A, B, ALU_OP, CF, VF, Shift_Carry_Out -> F, NZCV).
- Accepts data-processing requests over valid/ready, drives the ALU, registers the result and owns the architectural NZCV flag register.
- Supports an optional 64-bit two-pass mode: low word first, high word second with carry chained.
- Sits between decode/operand fetch and register-file writeback.

Parameters:
- W, 32, datapath word width. ALU interface fixed at 32; W is for documentation only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  ARM data-processing opcode (0000 AND … 1111 MVN)
- req_s  in  1  S bit: update flags
- req_wide  in  1  64-bit two-pass operation
- req_a  in  32  operand A, low word
- req_b  in  32  operand B, low word (post-shifter)
- req_a_hi  in  32  A high word; used only when req_wide
- req_b_hi  in  32  B high word; used only when req_wide
- req_shc  in  1  shifter carry-out for the low pass
- alu_a, alu_b  out  32  to ALU
- alu_op  out  4  to ALU
- alu_cf, alu_vf  out  1  to ALU CF/VF
- alu_shc  out  1  to ALU Shift_Carry_Out
- alu_f  in  32  ALU result
- alu_nzcv  in  4  ALU flags
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_f  out  32  low result word
- res_f_hi  out  32  high result word (0 when not wide)
- res_we  out  1  Rd writeback required
- flag_wr_en  in  1  external (MSR) flag write
- flag_wr_data  in  4  NZCV value for the external write
- nzcv  out  4  architectural flags

Behaviour:
- States: IDLE, EXEC_LO, EXEC_HI, DONE.
- Reset values: state=IDLE, req_ready=1, res_valid=0, res_f=0, res_f_hi=0, res_we=0, nzcv=0000, all alu_* outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and go to EXEC_LO.
  - Snapshot nzcv[1] (C) and nzcv[0] (V) as the ALU CF/VF.
- EXEC_LO:
  - alu_* outputs are registered from the latched low operands.
  - Capture alu_f and alu_nzcv at the end of the cycle.
  - If req_wide, go to EXEC_HI; otherwise go to DONE.
- EXEC_HI:
  - alu_a/alu_b = high words; alu_cf = low-pass C; alu_shc = low-pass C.
  - alu_op remap: ADD->ADC, SUB->SBC, RSB->RSC, CMP->SBC, CMN->ADC. All other opcodes unchanged.
  - Wide flags: N, C, V from the high pass; Z = Z_lo & Z_hi.
- Latency: req accepted at cycle 0 -> res_valid=1 at cycle 2 (narrow) or cycle 3 (wide).
- DONE:
  - res_valid=1; res_f, res_f_hi and res_we held stable until res_ready.
  - On res_valid & res_ready, go to IDLE. req_ready returns to 1 the following cycle; no back-to-back accept.
- res_we = 0 for opcodes 10xx (TST/TEQ/CMP/CMN); 1 otherwise.
- Flag update:
  - Happens on the cycle the block enters DONE, if req_s=1 or the opcode is 10xx.
  - Compare ops always update flags regardless of S.
- External write: flag_wr_en loads flag_wr_data into nzcv in any state. If it coincides with the internal flag update, the internal update wins and the external write is dropped.
- Flag snapshot: flag changes after EXEC_LO begins do not affect the operation in flight.
- rst mid-operation: abort, return to reset values, discard the in-flight request; no partial flag update.
- req_* signals are ignored whenever req_ready=0.

Test Plan:
- ADD narrow: A=ac963a55, B=365aacf9, op=0100, S=1, nzcv=0000 -> res_f=e2f0e74e, res_we=1, nzcv=1000, res_valid at cycle 2.
- SUB narrow, S=0: same operands, op=0010 -> res_f=763b8d5c, res_we=1, nzcv unchanged (0000).
- CMP, S=0: same operands, op=1010 -> res_we=0, nzcv=0011.
- Wide ADD: A={0,ffffffff}, B={0,00000001}, op=0100, S=1 -> res_f=00000000, res_f_hi=00000001, nzcv=0000 (Z=0 because the high word is nonzero). Wide ADD 0+0 -> Z=1.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_f stable, req_ready=0; release -> one handshake, then req_ready=1.
- Collision and reset:
  - flag_wr_en=1, data=1111, in the same cycle as a CMP flag update -> nzcv=CMP result.
  - flag_wr_en alone in IDLE -> nzcv=1111.
  - rst asserted in EXEC_HI -> next cycle IDLE, res_valid=0, nzcv=0000.
